// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter: opcodes, default widths and
// the arbiter FSM state type.
package alu_pkg;

    localparam int ALU_DW  = 32;
    localparam int ALU_OPW = 5;

    localparam logic [4:0] OP_NOP     = 5'h00;
    localparam logic [4:0] OP_ADD     = 5'h01;
    localparam logic [4:0] OP_SUB     = 5'h02;
    localparam logic [4:0] OP_AND     = 5'h03;
    localparam logic [4:0] OP_OR      = 5'h04;
    localparam logic [4:0] OP_XOR     = 5'h05;
    localparam logic [4:0] OP_NOR     = 5'h06;
    localparam logic [4:0] ALU_OP_MAX = 5'h06;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPT,
        ST_RESP
    } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to the port that was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       idx
);

    assign idx   = (req == 2'b11) ? ~last : req[1];
    assign grant = (req == 2'b00) ? 2'b00 : (idx ? 2'b10 : 2'b01);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin sequencer for the shared registered ALU: accepts one
// operation, waits out the ALU latency, and returns the result to its port.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_err,
    output logic           busy,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_out
);

    alu_arb_state_t state, state_nxt;
    logic           last_grant, gnt_q, idx;
    logic [1:0]     grant;
    logic [DW-1:0]  sel_a, sel_b;
    logic [OPW-1:0] sel_op;
    logic           sel_legal, accept, rsp_fire;

    rr_arb2 u_rr (
        .req   (req_valid),
        .last  (last_grant),
        .grant (grant),
        .idx   (idx)
    );

    assign sel_a     = idx ? req1_a  : req0_a;
    assign sel_b     = idx ? req1_b  : req0_b;
    assign sel_op    = idx ? req1_op : req0_op;
    assign sel_legal = (sel_op <= OPW'(ALU_OP_MAX));

    assign accept    = (state == ST_IDLE) && (req_valid != 2'b00);
    assign rsp_fire  = (state == ST_RESP) && rsp_ready[gnt_q];
    assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
    assign rsp_valid = (state == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Illegal opcodes skip the ALU entirely since it would only hold stale data.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = sel_legal ? ST_EXEC : ST_RESP;
            ST_EXEC: state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_RESP;
            ST_RESP: if (rsp_fire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OPW'(OP_NOP);
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q <= idx;
                        if (sel_legal) begin
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            alu_op <= sel_op;
                        end else begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_EXEC: ;
                // Operands stay put; only the opcode returns to NOP.
                ST_CAPT: begin
                    rsp_data <= alu_out;
                    rsp_err  <= 1'b0;
                    alu_op   <= OPW'(OP_NOP);
                end
                ST_RESP: if (rsp_fire) last_grant <= gnt_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter with a registered ALU model
// and a transaction-level reference checked on every cycle.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW  = 32;
    localparam int OPW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b, alu_out;
    logic [OPW-1:0] req0_op, req1_op, alu_op;
    logic           rsp_err, busy;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [4:0] op; } op_t;
    typedef struct { int port; logic [31:0] data; logic err; int lat; } obs_t;

    op_t  q0[$], q1[$];
    obs_t obs[$];
    int   checks = 0, passes = 0;
    int   rdy_mode = 0;
    bit   gap = 0;
    logic [1:0] acc_s = 2'b00;

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'h01:   return a + b;
            5'h02:   return a - b;
            5'h03:   return a & b;
            5'h04:   return a | b;
            5'h05:   return a ^ b;
            5'h06:   return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Registered ALU; NOP and undefined codes leave the result register alone.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= '0;
        else if (alu_op >= 5'd1 && alu_op <= 5'd6) alu_out <= alu_f(alu_op, alu_a, alu_b);
    end

    // Reference: at most one op in flight, response due 3 cycles after a legal
    // acceptance or 1 after an illegal one, released by the granted rsp_ready.
    bit         m_busy = 0, m_last = 1, m_g = 0, m_legal = 0, prev_vld = 0;
    int         m_cnt = 0, m_lat = 0, cyc = 0, t_acc = 0, rise = 0;
    op_t        m_req;
    logic [31:0] m_data;
    logic       m_err;

    always @(negedge clk) begin
        logic [1:0] ev;
        obs_t o;
        cyc++;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_alu_op", alu_op, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_err", rsp_err, 0);
            m_busy = 0; m_last = 1; m_cnt = 0; acc_s = 2'b00; prev_vld = 0;
        end else begin
            ev = m_busy ? 2'b00 : pick(req_valid, m_last);
            chk("req_ready", req_ready, ev);
            chk("busy", busy, m_busy);
            ev = (m_busy && m_cnt >= m_lat) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid", rsp_valid, ev);
            if (ev != 2'b00) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_err", rsp_err, m_err);
            end
            if (m_busy && m_legal && m_cnt <= 2) begin
                chk("alu_op", alu_op, m_req.op);
                chk("alu_a", alu_a, m_req.a);
                chk("alu_b", alu_b, m_req.b);
            end else begin
                chk("alu_op_nop", alu_op, 0);
            end

            acc_s = req_valid & req_ready;
            if (acc_s != 2'b00) t_acc = cyc;
            if (rsp_valid != 2'b00 && !prev_vld) rise = cyc;
            prev_vld = (rsp_valid != 2'b00);
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                o.port = rsp_valid[1] ? 1 : 0;
                o.data = rsp_data;
                o.err  = rsp_err;
                o.lat  = rise - t_acc;
                obs.push_back(o);
            end

            if (!m_busy) begin
                ev = pick(req_valid, m_last);
                if (ev != 2'b00) begin
                    m_g = ev[1];
                    m_req.a  = ev[1] ? req1_a  : req0_a;
                    m_req.b  = ev[1] ? req1_b  : req0_b;
                    m_req.op = ev[1] ? req1_op : req0_op;
                    m_legal  = (m_req.op <= 5'd6);
                    m_data   = m_legal ? alu_f(m_req.op, m_req.a, m_req.b) : 32'h0;
                    m_err    = !m_legal;
                    m_lat    = m_legal ? 3 : 1;
                    m_cnt    = 1;
                    m_busy   = 1;
                end
            end else if (m_cnt >= m_lat && rsp_ready[m_g]) begin
                m_busy = 0;
                m_last = m_g;
            end else if (m_cnt < m_lat) begin
                m_cnt++;
            end
        end
    end

    // Requests stay presented until accepted; gap mode may withdraw them meanwhile.
    always @(posedge clk) begin
        #1;
        if (acc_s[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc_s[1] && q1.size() > 0) void'(q1.pop_front());
        if (!rst_n || q0.size() == 0) req_valid[0] = 1'b0;
        else begin
            req_valid[0] = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op;
        end
        if (!rst_n || q1.size() == 0) req_valid[1] = 1'b0;
        else begin
            req_valid[1] = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
            req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op;
        end
        case (rdy_mode)
            0:       rsp_ready = 2'b11;
            1:       rsp_ready = 2'($urandom_range(0, 3));
            default: rsp_ready = 2'b00;
        endcase
    end

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        op_t t;
        t.a = a; t.b = b; t.op = op;
        return t;
    endfunction

    task automatic wait_done(input string nm, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && !busy && req_valid == 2'b00) && n < lim);
        chk({nm, "_done_in_time"}, n < lim, 1);
    endtask

    task automatic expect_rsp(input string nm, input int port, input logic [31:0] d, input logic e, input int lat);
        obs_t o;
        chk({nm, "_present"}, obs.size() > 0, 1);
        if (obs.size() > 0) begin
            o = obs.pop_front();
            chk({nm, "_port"}, o.port, port);
            chk({nm, "_data"}, o.data, d);
            chk({nm, "_err"}, o.err, e);
            chk({nm, "_lat"}, o.lat, lat);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
        req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        q0.push_back(mk(32'd5, 32'd3, OP_ADD));
        wait_done("add", 50);
        expect_rsp("add", 0, 32'h00000008, 0, 3);
        q1.push_back(mk(32'd3, 32'd5, OP_SUB));
        wait_done("sub", 50);
        expect_rsp("sub", 1, 32'hFFFFFFFE, 0, 3);
        q0.push_back(mk(32'd0, 32'd0, OP_NOR));
        wait_done("nor", 50);
        expect_rsp("nor", 0, 32'hFFFFFFFF, 0, 3);

        // Tie straight out of reset, then port 0 re-requests while port 1 waits.
        @(posedge clk); #2 rst_n = 1'b0;
        q0.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, OP_AND));
        q0.push_back(mk(32'd1, 32'd1, OP_ADD));
        q1.push_back(mk(32'h1, 32'h2, OP_OR));
        repeat (2) @(posedge clk); #2 rst_n = 1'b1;
        wait_done("tie", 100);
        expect_rsp("tie_and", 0, 32'hF000F000, 0, 3);
        expect_rsp("tie_or", 1, 32'h00000003, 0, 3);
        expect_rsp("tie_add", 0, 32'h00000002, 0, 3);

        q0.push_back(mk(32'd9, 32'd9, 5'h07));
        wait_done("ill0", 50);
        expect_rsp("ill0", 0, 32'h0, 1, 1);
        q1.push_back(mk(32'd9, 32'd9, 5'h1F));
        wait_done("ill1", 50);
        expect_rsp("ill1", 1, 32'h0, 1, 1);

        rdy_mode = 2;
        q0.push_back(mk(32'd7, 32'd9, OP_ADD));
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 20);
        chk("stall_reached", rsp_valid[0], 1);
        q1.push_back(mk(32'hA5, 32'h0F, OP_XOR));
        repeat (5) begin
            @(negedge clk);
            chk("stall_data", rsp_data, 32'd16);
            chk("stall_vld", rsp_valid, 2'b01);
            chk("stall_req_ready", req_ready, 2'b00);
        end
        rdy_mode = 0;
        wait_done("stall", 50);
        expect_rsp("stall_add", 0, 32'd16, 0, 3);
        expect_rsp("stall_xor", 1, 32'hAA, 0, 3);
        q0.push_back(mk(32'h1, 32'h2, OP_OR));
        wait_done("pre_rst", 50);
        expect_rsp("pre_rst", 0, 32'h3, 0, 3);

        // Reset while the ALU is executing: nothing may come back afterwards.
        q0.push_back(mk(32'd100, 32'd200, OP_ADD));
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 20);
        chk("mrst_pre_op", alu_op, OP_ADD);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_alu_op", alu_op, 0);
        chk("mrst_rsp_valid", rsp_valid, 0);
        chk("mrst_busy", busy, 0);
        repeat (2) @(posedge clk); #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mrst_no_rsp", obs.size(), 0);
        q0.push_back(mk(32'hFF, 32'h0F, OP_AND));
        q1.push_back(mk(32'd10, 32'd4, OP_SUB));
        wait_done("mrst_tie", 100);
        expect_rsp("mrst_tie0", 0, 32'h0F, 0, 3);
        expect_rsp("mrst_tie1", 1, 32'h6, 0, 3);

        rdy_mode = 1; gap = 1;
        for (int i = 0; i < 200; i++) begin
            op_t t;
            t.a  = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : 32'($urandom);
            t.b  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
            t.op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) q1.push_back(t);
            else q0.push_back(t);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_done("rand", 8000);
        obs.delete();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
